// File: rtl/instr_line_mem.sv
// Instruction-line memory: returns one aligned line per request, with a
// configurable miss latency and a single-entry line buffer for 1-cycle hits.
module instr_line_mem #(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 16,
   parameter int MEM_BYTES  = 1024,
   parameter int LATENCY    = 6,
   parameter int SWAP_MID   = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic                      flush,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [8*LINE_BYTES-1:0]   resp_line,
   output logic [ADDR_W-1:0]         resp_addr,
   output logic                      busy
);

   // state | meaning
   // IDLE  | ready for a request, req_ready high
   // WAIT  | miss in flight, counting towards LATENCY-1
   // RESP  | response presented (resp_valid rises one cycle after a hit)

   localparam int OFF     = $clog2(LINE_BYTES);
   localparam int TAG_W   = ADDR_W - OFF;
   localparam int MEM_AW  = $clog2(MEM_BYTES);
   localparam int LINE_W  = 8 * LINE_BYTES;
   localparam int CNT_W   = $clog2(LATENCY);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
   localparam bit   DO_SWAP = (SWAP_MID != 0) && (LINE_BYTES == 16);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [TAG_W-1:0]   req_tag_q;
   logic [TAG_W-1:0]   buf_tag;
   logic               buf_valid;
   logic [TAG_W-1:0]   req_tag;
   logic [ADDR_W-1:0]  line_base;
   logic               buf_hit;
   logic               unused_addr_bits;

   assign req_tag          = req_addr[ADDR_W-1:OFF];
   assign line_base        = {req_tag_q, {OFF{1'b0}}};
   assign buf_hit          = buf_valid && (buf_tag == req_tag) && !flush;
   assign unused_addr_bits = ^req_addr[OFF-1:0];

   // Storage content is fixed (byte i = i % 200), so it is generated from the index.
   function automatic logic [LINE_W-1:0] fetch_line(input logic [MEM_AW-1:0] base);
      logic [LINE_W-1:0] nat;
      logic [LINE_W-1:0] res;
      logic [MEM_AW-1:0] idx;
      for (int b = 0; b < LINE_BYTES; b++) begin
         idx = base + MEM_AW'(b);
         nat[8*b +: 8] = 8'(32'(idx) % 32'd200);
      end
      res = nat;
      if (DO_SWAP) begin
         res[32 +: 32] = nat[64 +: 32];
         res[64 +: 32] = nat[32 +: 32];
      end
      return res;
   endfunction

   // resp_line only changes on fills, so it doubles as the line buffer data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         req_tag_q  <= '0;
         buf_tag    <= '0;
         buf_valid  <= 1'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_line  <= '0;
         resp_addr  <= '0;
         busy       <= 1'b0;
      end else begin
         if (flush)
            buf_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  req_tag_q <= req_tag;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (buf_hit) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= '0;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == CNT_LAST) begin
                  resp_line  <= fetch_line(line_base[MEM_AW-1:0]);
                  resp_addr  <= line_base;
                  buf_tag    <= req_tag_q;
                  buf_valid  <= 1'b1;
                  resp_valid <= 1'b1;
                  state      <= S_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (!resp_valid) begin
                  resp_valid <= 1'b1;
                  resp_addr  <= line_base;
               end else if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_line_mem.sv
// Bench for instr_line_mem: default configuration plus a 32-byte, latency-2,
// natural-order instance.
module tb_instr_line_mem;

   logic clk;
   logic rst_n;

   logic          a_req_valid, a_req_ready, a_flush, a_resp_valid, a_resp_ready, a_busy;
   logic [31:0]   a_req_addr, a_resp_addr;
   logic [127:0]  a_resp_line;

   logic          b_req_valid, b_req_ready, b_flush, b_resp_valid, b_resp_ready, b_busy;
   logic [31:0]   b_req_addr, b_resp_addr;
   logic [255:0]  b_resp_line;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   typedef struct { logic [127:0] line; logic [31:0] addr; int lat; } exp_a_t;
   typedef struct { logic [255:0] line; logic [31:0] addr; int lat; } exp_b_t;
   exp_a_t sbq_a[$];
   exp_b_t sbq_b[$];

   localparam logic [127:0] L0 = 128'h0F0E0D0C_07060504_0B0A0908_03020100;

   instr_line_mem #(.ADDR_W(32), .LINE_BYTES(16), .MEM_BYTES(1024), .LATENCY(6), .SWAP_MID(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_addr(a_req_addr), .flush(a_flush), .resp_valid(a_resp_valid),
      .resp_ready(a_resp_ready), .resp_line(a_resp_line), .resp_addr(a_resp_addr), .busy(a_busy));

   instr_line_mem #(.ADDR_W(32), .LINE_BYTES(32), .MEM_BYTES(1024), .LATENCY(2), .SWAP_MID(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_addr(b_req_addr), .flush(b_flush), .resp_valid(b_resp_valid),
      .resp_ready(b_resp_ready), .resp_line(b_resp_line), .resp_addr(b_resp_addr), .busy(b_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] m_byte(input int unsigned i);
      return 8'((i % 1024) % 200);
   endfunction

   function automatic logic [127:0] m_line16(input logic [31:0] a);
      logic [31:0] base;
      logic [31:0] w [4];
      base = a & ~32'hF;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++)
            w[k][8*j +: 8] = m_byte(base + 32'(4*k + j));
      return {w[3], w[1], w[2], w[0]};
   endfunction

   function automatic logic [255:0] m_line32(input logic [31:0] a);
      logic [31:0]  base;
      logic [255:0] l;
      base = a & ~32'h1F;
      for (int i = 0; i < 32; i++)
         l[8*i +: 8] = m_byte(base + 32'(i));
      return l;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic a_issue(input logic [31:0] addr, input logic fl);
      int n = 0;
      a_req_valid = 1'b1;
      a_req_addr  = addr;
      a_flush     = fl;
      while (!a_req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      a_req_valid = 1'b0;
      a_flush     = 1'b0;
   endtask

   task automatic a_collect(output logic [127:0] line, output logic [31:0] addr, output int lat);
      int n = 0;
      while (!a_resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      lat  = a_resp_valid ? n : -1;
      line = a_resp_line;
      addr = a_resp_addr;
   endtask

   task automatic a_consume;
      a_resp_ready = 1'b1;
      @(negedge clk);
      a_resp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0 || a_busy !== 1'b0)
         $display("FAIL reset_ctrl: ready/valid/busy=%b%b%b want 100", a_req_ready, a_resp_valid, a_busy);
      else pass_cnt++;
      chk_cnt++;
      if (a_resp_line !== 128'h0) $display("FAIL reset_line: got %h want 0", a_resp_line);
      else pass_cnt++;
      chk_cnt++;
      if (a_resp_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", a_resp_addr);
      else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0 || b_req_ready !== 1'b1)
         $display("FAIL post_reset_idle: a_ready/a_valid/b_ready=%b%b%b want 101", a_req_ready, a_resp_valid, b_req_ready);
      else pass_cnt++;
   endtask

   task automatic test_miss_basic;
      logic [127:0] l; logic [31:0] ad; int n; exp_a_t e;
      sbq_a.push_back('{L0, 32'h0, 6});
      a_issue(32'h000, 1'b0);
      chk_cnt++;
      if (a_busy !== 1'b1 || a_req_ready !== 1'b0)
         $display("FAIL wait_busy: busy/ready=%b%b want 10", a_busy, a_req_ready);
      else pass_cnt++;
      a_collect(l, ad, n);
      e = sbq_a.pop_front();
      chk_cnt++; if (n !== e.lat) $display("FAIL miss0_lat: got %0d want %0d", n, e.lat); else pass_cnt++;
      chk_cnt++; if (l !== e.line) $display("FAIL miss0_line: got %h want %h", l, e.line); else pass_cnt++;
      chk_cnt++; if (ad !== e.addr) $display("FAIL miss0_addr: got %h want %h", ad, e.addr); else pass_cnt++;
      a_consume();
   endtask

   task automatic test_hit;
      logic [127:0] l; logic [31:0] ad; int n; exp_a_t e;
      sbq_a.push_back('{L0, 32'h0, 1});
      a_issue(32'h004, 1'b0);
      a_collect(l, ad, n);
      e = sbq_a.pop_front();
      chk_cnt++; if (n !== e.lat) $display("FAIL hit_lat: got %0d want %0d", n, e.lat); else pass_cnt++;
      chk_cnt++; if (l !== e.line) $display("FAIL hit_line: got %h want %h", l, e.line); else pass_cnt++;
      chk_cnt++; if (ad !== e.addr) $display("FAIL hit_addr: got %h want %h", ad, e.addr); else pass_cnt++;
      a_consume();
   endtask

   task automatic test_wrap200;
      logic [127:0] l; logic [31:0] ad; int n; exp_a_t e;
      sbq_a.push_back('{128'h07060504_C7C6C5C4_03020100_C3C2C1C0, 32'h0C0, 6});
      a_issue(32'h0C8, 1'b0);
      a_collect(l, ad, n);
      e = sbq_a.pop_front();
      chk_cnt++; if (n !== e.lat) $display("FAIL wrap200_lat: got %0d want %0d", n, e.lat); else pass_cnt++;
      chk_cnt++; if (l !== e.line) $display("FAIL wrap200_line: got %h want %h", l, e.line); else pass_cnt++;
      chk_cnt++; if (ad !== e.addr) $display("FAIL wrap200_addr: got %h want %h", ad, e.addr); else pass_cnt++;
      a_consume();
   endtask

   task automatic test_addr_wrap;
      logic [127:0] l; logic [31:0] ad; int n; exp_a_t e;
      sbq_a.push_back('{L0, 32'h400, 6});
      a_issue(32'h400, 1'b0);
      a_collect(l, ad, n);
      e = sbq_a.pop_front();
      chk_cnt++; if (n !== e.lat) $display("FAIL memwrap_lat: got %0d want %0d", n, e.lat); else pass_cnt++;
      chk_cnt++; if (l !== e.line) $display("FAIL memwrap_line: got %h want %h", l, e.line); else pass_cnt++;
      chk_cnt++; if (ad !== e.addr) $display("FAIL memwrap_addr: got %h want %h", ad, e.addr); else pass_cnt++;
      a_consume();
   endtask

   task automatic test_hold_flush;
      logic [127:0] l; logic [31:0] ad; int n; exp_a_t e;
      logic stable, rdy_low;
      sbq_a.push_back('{L0, 32'h400, 1});
      a_issue(32'h40C, 1'b0);
      a_collect(l, ad, n);
      e = sbq_a.pop_front();
      chk_cnt++; if (n !== e.lat) $display("FAIL hold_hit_lat: got %0d want %0d", n, e.lat); else pass_cnt++;
      chk_cnt++; if (l !== e.line) $display("FAIL hold_hit_line: got %h want %h", l, e.line); else pass_cnt++;
      stable  = 1'b1;
      rdy_low = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a_flush = (i == 2);
         @(negedge clk);
         if (a_resp_valid !== 1'b1 || a_resp_line !== e.line || a_resp_addr !== e.addr) stable = 1'b0;
         if (a_req_ready !== 1'b0) rdy_low = 1'b0;
      end
      a_flush = 1'b0;
      chk_cnt++; if (stable !== 1'b1) $display("FAIL hold_stable: got %b want 1", stable); else pass_cnt++;
      chk_cnt++; if (rdy_low !== 1'b1) $display("FAIL hold_req_ready_low: got %b want 1", rdy_low); else pass_cnt++;
      a_consume();
      sbq_a.push_back('{L0, 32'h400, 6});
      a_issue(32'h400, 1'b0);
      a_collect(l, ad, n);
      e = sbq_a.pop_front();
      chk_cnt++; if (n !== e.lat) $display("FAIL flush_in_resp_lat: got %0d want %0d", n, e.lat); else pass_cnt++;
      a_consume();
      sbq_a.push_back('{L0, 32'h400, 6});
      a_issue(32'h404, 1'b1);
      a_collect(l, ad, n);
      e = sbq_a.pop_front();
      chk_cnt++; if (n !== e.lat) $display("FAIL flush_at_accept_lat: got %0d want %0d", n, e.lat); else pass_cnt++;
      chk_cnt++; if (l !== e.line || ad !== e.addr)
         $display("FAIL flush_at_accept_data: got %h/%h want %h/%h", l, ad, e.line, e.addr);
      else pass_cnt++;
      a_consume();
   endtask

   task automatic test_flush_wait;
      logic [127:0] l; logic [31:0] ad; int n; exp_a_t e;
      sbq_a.push_back('{m_line16(32'h100), 32'h100, 6});
      a_issue(32'h100, 1'b0);
      a_flush = 1'b1;
      @(negedge clk);
      a_flush = 1'b0;
      a_collect(l, ad, n);
      e = sbq_a.pop_front();
      chk_cnt++; if (n !== e.lat - 1) $display("FAIL flush_wait_lat: got %0d want %0d", n + 1, e.lat); else pass_cnt++;
      chk_cnt++; if (l !== e.line) $display("FAIL flush_wait_line: got %h want %h", l, e.line); else pass_cnt++;
      a_consume();
      sbq_a.push_back('{m_line16(32'h100), 32'h100, 1});
      a_issue(32'h10C, 1'b0);
      a_collect(l, ad, n);
      e = sbq_a.pop_front();
      chk_cnt++; if (n !== e.lat) $display("FAIL flush_wait_hit_lat: got %0d want %0d", n, e.lat); else pass_cnt++;
      chk_cnt++; if (ad !== e.addr) $display("FAIL flush_wait_hit_addr: got %h want %h", ad, e.addr); else pass_cnt++;
      a_consume();
   endtask

   task automatic test_back_to_back;
      logic [127:0] l; logic [31:0] ad, a; int n; exp_a_t e;
      logic mvalid; logic [27:0] mtag;
      a_flush = 1'b1;
      @(negedge clk);
      a_flush = 1'b0;
      mvalid = 1'b0;
      mtag   = '0;
      for (int i = 0; i < 10; i++) begin
         a = 32'($urandom_range(0, 1)) * 32'h400 + 32'($urandom_range(0, 3)) * 32'h10
           + 32'($urandom_range(0, 15));
         sbq_a.push_back('{m_line16(a), a & ~32'hF, (mvalid && mtag == a[31:4]) ? 1 : 6});
         mvalid = 1'b1;
         mtag   = a[31:4];
         a_issue(a, 1'b0);
         a_collect(l, ad, n);
         e = sbq_a.pop_front();
         chk_cnt++;
         if (n !== e.lat || l !== e.line || ad !== e.addr)
            $display("FAIL b2b_%0d addr %h: got lat %0d %h/%h want lat %0d %h/%h",
                     i, a, n, l, ad, e.lat, e.line, e.addr);
         else pass_cnt++;
         a_consume();
      end
   endtask

   task automatic test_reset_mid_wait;
      logic [127:0] l; logic [31:0] ad; int n; exp_a_t e;
      logic stale;
      a_issue(32'h200, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0)
         $display("FAIL rst_wait_ctrl: valid/ready/busy=%b%b%b want 010", a_resp_valid, a_req_ready, a_busy);
      else pass_cnt++;
      chk_cnt++;
      if (a_resp_line !== 128'h0 || a_resp_addr !== 32'h0)
         $display("FAIL rst_wait_data: got %h/%h want 0/0", a_resp_line, a_resp_addr);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      stale = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (a_resp_valid !== 1'b0) stale = 1'b1;
      end
      chk_cnt++; if (stale !== 1'b0) $display("FAIL rst_no_stale: got %b want 0", stale); else pass_cnt++;
      sbq_a.push_back('{m_line16(32'h200), 32'h200, 6});
      a_issue(32'h200, 1'b0);
      a_collect(l, ad, n);
      e = sbq_a.pop_front();
      chk_cnt++;
      if (n !== e.lat || l !== e.line || ad !== e.addr)
         $display("FAIL rst_remiss: got lat %0d %h/%h want lat %0d %h/%h", n, l, ad, e.lat, e.line, e.addr);
      else pass_cnt++;
      a_consume();
   endtask

   task automatic test_cfg_b;
      logic [31:0] addrs [3] = '{32'h020, 32'h3E0, 32'h3E4};
      int          lats  [3] = '{2, 2, 1};
      exp_b_t e;
      int n;
      for (int i = 0; i < 3; i++) begin
         sbq_b.push_back('{m_line32(addrs[i]), addrs[i] & ~32'h1F, lats[i]});
         b_req_valid = 1'b1;
         b_req_addr  = addrs[i];
         n = 0;
         while (!b_req_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         @(posedge clk);
         @(negedge clk);
         b_req_valid = 1'b0;
         n = 0;
         while (!b_resp_valid && n < 40) begin
            @(negedge clk);
            n++;
         end
         if (!b_resp_valid) n = -1;
         e = sbq_b.pop_front();
         chk_cnt++; if (n !== e.lat) $display("FAIL cfgb_%0d_lat: got %0d want %0d", i, n, e.lat); else pass_cnt++;
         chk_cnt++; if (b_resp_line !== e.line) $display("FAIL cfgb_%0d_line: got %h want %h", i, b_resp_line, e.line); else pass_cnt++;
         chk_cnt++; if (b_resp_addr !== e.addr) $display("FAIL cfgb_%0d_addr: got %h want %h", i, b_resp_addr, e.addr); else pass_cnt++;
         if (i == 0) begin
            chk_cnt++;
            if (b_resp_line[31:0] !== 32'h23222120) $display("FAIL cfgb_w0: got %h want 23222120", b_resp_line[31:0]);
            else pass_cnt++;
         end
         b_resp_ready = 1'b1;
         @(negedge clk);
         b_resp_ready = 1'b0;
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      a_req_valid  = 1'b0; a_req_addr = '0; a_flush = 1'b0; a_resp_ready = 1'b0;
      b_req_valid  = 1'b0; b_req_addr = '0; b_flush = 1'b0; b_resp_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_miss_basic();
      test_hit();
      test_wrap200();
      test_addr_wrap();
      test_hold_flush();
      test_flush_wait();
      test_back_to_back();
      test_reset_mid_wait();
      test_cfg_b();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/instr_line_mem.md
Name: instr_line_mem

Overview:
- Parametrised instruction-line memory. Returns one aligned line of LINE_BYTES bytes per request over valid/ready handshakes.
- Miss latency is configurable. A single-entry line buffer gives 1-cycle hits on repeated line addresses.
- A flush input invalidates the buffer, e.g. on self-modifying code or a context switch.
- Sits between the fetch stage and backing storage, and feeds the I-cache refill path.

Parameters:
ADDR_W, 32, request address width in bits
LINE_BYTES, 16, bytes per line; power of two, >=4, multiple of 4
MEM_BYTES, 1024, storage size in bytes; power of two, >=LINE_BYTES
LATENCY, 6, cycles from miss acceptance to resp_valid; >=2
SWAP_MID, 1, 1: word order {w3,w1,w2,w0} (legal only with LINE_BYTES=16); 0: natural order {w(n-1)..w0}

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_addr  in  ADDR_W  byte address; low log2(LINE_BYTES) bits ignored
flush  in  1  invalidate line buffer
resp_valid  out  1  resp_line/resp_addr valid
resp_ready  in  1  consumer accepts response
resp_line  out  8*LINE_BYTES  line data, little-endian words
resp_addr  out  ADDR_W  line-aligned base address of resp_line
busy  out  1  high in WAIT or RESP

Behaviour:
- Storage: byte array MEM_BYTES deep, initialised so byte i = i % 200 for every i, including the last byte.
  - Index = line base modulo MEM_BYTES, i.e. upper address bits wrap.
  - Word k = bytes base+4k+3..base+4k, little-endian.
- Reset (rst_n low, asynchronous): state IDLE, req_ready 1, resp_valid 0, resp_line 0, resp_addr 0, busy 0, buffer invalid, counter 0.
  - Reset mid-WAIT or mid-RESP abandons the request. No response is produced.
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE).
  - IDLE: on req_valid&&req_ready, latch the line base.
    - Hit (buffer valid, tag equals req_addr[ADDR_W-1:log2 LINE_BYTES], flush low): go to RESP. resp_valid rises on the next edge, T+1.
    - Otherwise (miss): go to WAIT, counter cleared.
  - WAIT: counter increments each cycle. When the counter reaches LATENCY-1:
    - load resp_line from storage and resp_addr;
    - set buffer tag and valid;
    - go to RESP.
    - resp_valid rises exactly LATENCY edges after acceptance.
  - RESP: resp_valid, resp_line and resp_addr are held stable until resp_valid&&resp_ready. On that edge go to IDLE and drop resp_valid. No combinational path from resp_ready to req_ready.
- Flush:
  - Clears buffer valid on the edge it is sampled.
  - Flush coincident with request acceptance: flush wins and the request is a miss.
  - Flush during WAIT: the fill still completes and sets valid.
  - Flush during RESP: the held response is unaffected; the buffer is invalidated.
- resp_line keeps its last value while resp_valid is low.
- Requests while req_ready is low are ignored. The requester must hold req_valid.

Test Plan:
- Reset, then req_addr 0x000 accepted at T (SWAP_MID=1) -> resp_valid at T+6, resp_addr 0x000, resp_line 0x0F0E0D0C_07060504_0B0A0908_03020100.
- Consume, then req_addr 0x004 -> hit, resp_valid at T+1, same line.
- req_addr 0x0C8 -> miss, resp_addr 0x0C0, words w0=0xC3C2C1C0, w1=0xC7C6C5C4, w2=0x03020100, w3=0x07060504 (200-wrap of init pattern).
- req_addr 0x400 -> wraps to storage 0x000, line identical to scenario 1, resp_addr 0x400, latency 6 (tag differs).
- Hold resp_ready low 5 cycles in RESP -> resp_valid, resp_line and resp_addr stable; req_ready 0. Assert flush with a hit-address request -> serviced as miss (latency 6).
- rst_n low at cycle 3 of WAIT -> all outputs reset immediately. After release, the same address misses; no stale resp_valid.
- SWAP_MID=0, LINE_BYTES=32, LATENCY=2, req 0x020 -> resp_valid at T+2, line = bytes 0x20..0x3F in natural order (w0=0x23222120).
